// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared edge/center-aligned counter with
// double-buffered period/duty/mode that switches over only on a period boundary.
module pwm_multi_channel #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic                    mode,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    cycle_start,
    output logic                    load_pending
);

    logic [CNT_W-1:0]        cnt_p0;
    logic                    dir_up_p0;
    logic [CNT_W-1:0]        act_period;
    logic [NUM_CH*CNT_W-1:0] act_duty;
    logic                    act_mode;
    logic [CNT_W-1:0]        sh_period;
    logic [NUM_CH*CNT_W-1:0] sh_duty;
    logic                    sh_mode;
    logic                    pend;

    logic                    per_bnd;
    logic                    bnd;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    dir_nxt;
    logic [NUM_CH-1:0]       pwm_nxt;
    logic                    cs_nxt;
    logic [NUM_CH-1:0]       pwm_p1;
    logic                    cs_p1;

    function automatic logic duty_hit(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] d);
        return c < d;
    endfunction

    // Stage 0: boundary detect and counter next-state
    always_comb begin
        per_bnd = 1'b0;
        if (act_period == '0) begin
            per_bnd = 1'b1;
        end else if (!act_mode) begin
            per_bnd = (cnt_p0 == act_period);
        end else begin
            // P==1 in center mode has no down leg, so the top of the ramp ends the period
            per_bnd = (cnt_p0 == CNT_W'(1)) && (!dir_up_p0 || act_period == CNT_W'(1));
        end
    end

    // An idle counter is always at a boundary, so loads and pending values apply at once
    assign bnd = !enable || per_bnd;

    always_comb begin
        cnt_nxt = cnt_p0;
        dir_nxt = dir_up_p0;
        if (bnd) begin
            cnt_nxt = '0;
            dir_nxt = 1'b1;
        end else if (!act_mode) begin
            cnt_nxt = cnt_p0 + CNT_W'(1);
        end else if (dir_up_p0) begin
            if (cnt_p0 == act_period) begin
                cnt_nxt = act_period - CNT_W'(1);
                dir_nxt = 1'b0;
            end else begin
                cnt_nxt = cnt_p0 + CNT_W'(1);
            end
        end else begin
            cnt_nxt = cnt_p0 - CNT_W'(1);
        end
    end

    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_nxt[i] = enable && duty_hit(cnt_p0, act_duty[i*CNT_W +: CNT_W]);
        end
        cs_nxt = enable && (cnt_p0 == '0) && dir_up_p0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0     <= '0;
            dir_up_p0  <= 1'b1;
            act_period <= '1;
            act_duty   <= '0;
            act_mode   <= 1'b0;
            sh_period  <= '1;
            sh_duty    <= '0;
            sh_mode    <= 1'b0;
            pend       <= 1'b0;
        end else begin
            cnt_p0    <= cnt_nxt;
            dir_up_p0 <= dir_nxt;
            if (load) begin
                sh_period <= period;
                sh_duty   <= duty;
                sh_mode   <= mode;
            end
            if (load && bnd) begin
                act_period <= period;
                act_duty   <= duty;
                act_mode   <= mode;
                pend       <= 1'b0;
            end else if (load) begin
                pend <= 1'b1;
            end else if (bnd && pend) begin
                act_period <= sh_period;
                act_duty   <= sh_duty;
                act_mode   <= sh_mode;
                pend       <= 1'b0;
            end
        end
    end

    // Stage 1: registered comparator outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_p1 <= '0;
            cs_p1  <= 1'b0;
        end else begin
            pwm_p1 <= pwm_nxt;
            cs_p1  <= cs_nxt;
        end
    end

    assign pwm_out      = pwm_p1;
    assign cycle_start  = cs_p1;
    assign load_pending = pend;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed self-checking bench for pwm_multi_channel (NUM_CH=4, CNT_W=8).
module tb_pwm_multi_channel;

    logic        clk = 1'b0;
    logic        reset, enable, load, mode;
    logic [7:0]  period;
    logic [31:0] duty;
    logic [3:0]  pwm_out;
    logic        cycle_start, load_pending;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_multi_channel #(.NUM_CH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .period(period), .duty(duty), .mode(mode),
        .pwm_out(pwm_out), .cycle_start(cycle_start), .load_pending(load_pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] p, input logic cs, input logic lp);
        chk({tag, "_pwm"}, 32'(pwm_out), 32'(p));
        chk({tag, "_cs"}, 32'(cycle_start), 32'(cs));
        chk({tag, "_pend"}, 32'(load_pending), 32'(lp));
    endtask

    initial begin
        int c;
        int d1;
        int hi;
        int seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

        // reset overrides enable and load
        reset = 1'b1; enable = 1'b1; load = 1'b1;
        period = 8'd9; duty = 32'h0A090300; mode = 1'b0;
        repeat (2) begin
            tick();
            chk_all("reset", 4'b0000, 1'b0, 1'b0);
        end
        reset = 1'b0; enable = 1'b0; load = 1'b0;
        repeat (3) begin
            tick();
            chk_all("post_reset", 4'b0000, 1'b0, 1'b0);
        end

        // edge mode, P=9, duty {10,9,3,0}; load while idle goes straight to active
        load = 1'b1;
        tick();
        chk("idle_load_pend", 32'(load_pending), 32'd0);
        load = 1'b0; enable = 1'b1;
        hi = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            c = (k - 1) % 10;
            chk_all("edge", {1'b1, c < 9, c < 3, 1'b0}, c == 0, 1'b0);
            if (k > 10 && pwm_out[1]) hi++;
        end
        chk("edge_ch1_high", 32'(hi), 32'd3);

        // shadow update: ch1 duty 3 -> 5 loaded at counter==4
        hi = 0;
        for (int k = 21; k <= 40; k++) begin
            load = (k == 25);
            if (k == 25) duty = 32'h0A090500;
            tick();
            c = (k - 1) % 10;
            d1 = (k <= 30) ? 3 : 5;
            chk_all("shadow", {1'b1, c < 9, c < d1, 1'b0}, c == 0, (k >= 25 && k <= 29));
            if (pwm_out[1]) hi++;
            if (k == 30) begin
                chk("shadow_ch1_old_high", 32'(hi), 32'd3);
                hi = 0;
            end
        end
        chk("shadow_ch1_new_high", 32'(hi), 32'd5);

        // load coinciding with the boundary: P=4 loaded on counter==9
        for (int k = 41; k <= 50; k++) begin
            load = (k == 50);
            if (k == 50) period = 8'd4;
            tick();
            c = (k - 1) % 10;
            chk_all("pre_bnd_load", {1'b1, c < 9, c < 5, 1'b0}, c == 0, 1'b0);
        end
        load = 1'b0;
        for (int k = 51; k <= 56; k++) begin
            tick();
            c = (k - 51) % 5;
            chk_all("bnd_load_p4", 4'b1110, c == 0, 1'b0);
        end

        // center mode, P=4, ch0=2, loaded mid-period
        load = 1'b1; period = 8'd4; duty = 32'h00000002; mode = 1'b1;
        tick();
        chk_all("ctr_load_c1", 4'b1110, 1'b0, 1'b1);
        load = 1'b0;
        tick();
        chk_all("ctr_load_c2", 4'b1110, 1'b0, 1'b1);
        tick();
        chk_all("ctr_load_c3", 4'b1110, 1'b0, 1'b1);
        tick();
        chk_all("ctr_load_c4", 4'b1110, 1'b0, 1'b0);
        hi = 0;
        for (int j = 0; j < 16; j++) begin
            tick();
            chk_all("center", {3'b000, seq[j % 8] < 2}, (j % 8) == 0, 1'b0);
            if (j < 8 && pwm_out[0]) hi++;
        end
        chk("center_ch0_high", 32'(hi), 32'd3);

        // mid-run reset with a pending load, then disable, then enable
        enable = 1'b0; load = 1'b1; period = 8'd9; duty = 32'h0A090300; mode = 1'b0;
        tick();
        chk_all("disabled_load", 4'b0000, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b1;
        repeat (3) tick();
        load = 1'b1; period = 8'd4;
        tick();
        chk("midrun_pend", 32'(load_pending), 32'd1);
        load = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk_all("midrun_reset", 4'b0000, 1'b0, 1'b0);
        reset = 1'b0; enable = 1'b0;
        repeat (3) begin
            tick();
            chk_all("disabled", 4'b0000, 1'b0, 1'b0);
        end
        enable = 1'b1;
        tick();
        chk_all("enable_rise", 4'b0000, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            chk_all("after_enable", 4'b0000, 1'b0, 1'b0);
        end

        // P==0: every cycle is a boundary, counter stays at 0
        enable = 1'b0; load = 1'b1; period = 8'd0; duty = 32'h00000001; mode = 1'b0;
        tick();
        load = 1'b0; enable = 1'b1;
        repeat (4) begin
            tick();
            chk_all("p_zero", 4'b0001, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
- REQ-001: Parameter NUM_CH, default 4: number of independent PWM output channels, range 1..16.
- REQ-002: Parameter CNT_W, default 8: width of the counter, period and per-channel duty, range 2..16.
- REQ-003: clk, input, 1: single clock; all state SHALL update on its rising edge.
- REQ-004: reset, input, 1: synchronous, active-high reset.
- REQ-005: enable, input, 1: 1 = run the counter, 0 = hold it idle.
- REQ-006: load, input, 1: single-cycle strobe that captures period, duty and mode into the shadow registers.
- REQ-007: period, input, CNT_W: terminal count P.
- REQ-008: duty, input, NUM_CH*CNT_W: per-channel duty D[i]; channel i occupies bits [i*CNT_W +: CNT_W].
- REQ-009: mode, input, 1: 0 = edge-aligned, 1 = center-aligned.
- REQ-010: pwm_out, output, NUM_CH: registered PWM outputs.
- REQ-011: cycle_start, output, 1: registered one-cycle pulse marking the first cycle of each PWM period.
- REQ-012: load_pending, output, 1: 1 while shadow values wait to be applied.

Function
- REQ-013: The block SHALL hold two register sets: shadow (period, duty, mode) and active (period, duty, mode); only the active set drives the counter and comparators.
- REQ-014: Edge mode SHALL count up 0,1,…,P, then wrap to 0; PWM period = P+1 cycles; boundary cycle = counter==P.
- REQ-015: Center mode SHALL count up 0→P, then down P-1→1, then restart at 0 with direction up; PWM period = 2P cycles; boundary cycle = counter==1 with direction down.
- REQ-016: With P==0, every cycle SHALL be a boundary cycle and the counter SHALL stay at 0, in both modes.
- REQ-017: load with no boundary in the same cycle SHALL write the shadow set and set load_pending; a further load before the boundary SHALL overwrite the shadow set (last write wins).
- REQ-018: On a boundary cycle with load_pending=1, shadow SHALL copy to active, load_pending SHALL clear, and the counter SHALL restart at 0 with direction up, including on a mode change.
- REQ-019: load coinciding with a boundary cycle SHALL write the inputs directly to active, and load_pending SHALL be 0 on the next cycle.
- REQ-020: While enable=0: counter SHALL be held at 0 with direction up, pwm_out SHALL be 0, and cycle_start SHALL be 0; a load SHALL write active directly, with load_pending=0.
- REQ-021: When enable rises, the first counted value SHALL be 0, and cycle_start SHALL pulse one cycle later.
- REQ-022: pwm_out[i] at cycle t+1 SHALL equal (counter(t) < D[i]) from active duty, as an unsigned compare; latency is 1 cycle.
- REQ-023: D[i]==0 SHALL give constant 0; in edge mode, D[i] ≥ P+1 SHALL give constant 1; in center mode, D[i] > P SHALL give constant 1.
- REQ-024: cycle_start at t+1 SHALL equal (enable && counter(t)==0 && direction up).
- REQ-025: Counter arithmetic SHALL be CNT_W bits wide, SHALL never exceed P, and SHALL not overflow at P = 2^CNT_W−1.
- REQ-026: The channels SHALL share one counter; each channel's duty SHALL act independently.

Reset
- REQ-027: While reset=1 at a clock edge, the block SHALL set: counter=0, direction up, active period={CNT_W{1}}, active duty=0, active mode=0, shadow set equal to active, load_pending=0, pwm_out=0, cycle_start=0.
- REQ-028: reset SHALL override enable and load in the same cycle.
- REQ-029: Reset mid-period SHALL discard the pending shadow values.

Verification (CNT_W=8, NUM_CH=4)
- REQ-030: Reset check: assert reset for 2 cycles with enable=1 and load=1 -> pwm_out=0, cycle_start=0, load_pending=0 on every cycle, and after release all outputs are 0 until a load.
- REQ-031: Edge mode: load P=9, duty={0,3,9,10}, mode=0, enable=1 -> per 10-cycle period, ch0 is always 0, ch1 is high 3 cycles, ch2 is high 9 cycles, ch3 is always 1, and cycle_start fires every 10 cycles aligned with the rising edge of ch1.
- REQ-032: Shadow update: while running P=9 with ch1=3, load ch1=5 at counter==4 -> load_pending=1 through counter==9, ch1 stays at 3 high cycles in the current period, then 5 high cycles in the next, and load_pending=0 from the first cycle of the next period.
- REQ-033: Center mode: load P=4, ch0=2, mode=1 -> counter sequence 0,1,2,3,4,3,2,1 repeats every 8 cycles, ch0 is high for counters 1,0,1 (3 contiguous cycles centered on 0), and cycle_start fires every 8 cycles.
- REQ-034: Load coinciding with the boundary: assert load with P=4 exactly on counter==9 of a P=9 run -> no load_pending, and the next period is 5 cycles long.
- REQ-035: Mid-run reset and disable: assert reset at counter==6, then hold enable=0 for 3 cycles, then set enable=1 -> outputs 0 throughout, and cycle_start fires 1 cycle after enable rises with the reset active values.
